// File: rtl/pool2x2_stream.sv
// Streaming 2x2 / stride-2 max or average pooling over a raster-order pixel stream.
// Horizontal pairs are combined on the fly; a half-width row buffer holds even-row partials.
module pool2x2_stream #(
   parameter int DW     = 8,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int SIGNED = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          mode,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last
);

   // Column counter is at least 2 bits so col[CW-1:1] is always a legal buffer index.
   localparam int CW = (IMG_W > 4) ? $clog2(IMG_W) : 2;
   localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int BD = 2 ** (CW - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic SGN = (SIGNED != 0);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [DW-1:0] pair_reg_q;
   logic          frame_mode_q;
   logic          out_valid_q;
   logic [DW-1:0] out_data_q;
   logic          out_last_q;
   logic [DW:0]   rowbuf_q [BD];

   logic          accept;
   logic          produce;
   logic [DW:0]   pa, pb, pair_res, rb_rd;
   logic [DW+1:0] sum;
   logic [DW-1:0] pool_res;
   logic          sum_unused;

   function automatic logic gt(input logic [DW:0] a, input logic [DW:0] b);
      if (SGN) return $signed(a) > $signed(b);
      else     return a > b;
   endfunction

   always_comb begin
      in_ready = !reset && (!out_valid_q || out_ready);
      accept   = in_valid && in_ready;
      produce  = accept && col_q[0] && row_q[0];

      pa       = {SGN & pair_reg_q[DW-1], pair_reg_q};
      pb       = {SGN & in_data[DW-1], in_data};
      pair_res = frame_mode_q ? (pa + pb) : (gt(pb, pa) ? pb : pa);

      // The low DW bits of the shifted sum are the same for arithmetic and logical shifts.
      rb_rd      = rowbuf_q[col_q[CW-1:1]];
      sum        = {SGN & rb_rd[DW], rb_rd} + {SGN & pair_res[DW], pair_res};
      sum_unused = ^sum[1:0];
      pool_res   = frame_mode_q ? sum[DW+1:2]
                 : (gt(pair_res, rb_rd) ? pair_res[DW-1:0] : rb_rd[DW-1:0]);

      col_d = col_q + 1'b1;
      row_d = row_q;
      if (col_q == COL_LAST) begin
         col_d = '0;
         row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q        <= '0;
         row_q        <= '0;
         pair_reg_q   <= '0;
         frame_mode_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
      end else begin
         if (accept) begin
            col_q <= col_d;
            row_q <= row_d;
            if (col_q == '0 && row_q == '0) frame_mode_q <= mode;
            if (!col_q[0]) pair_reg_q <= in_data;
         end
         if (produce) begin
            out_valid_q <= 1'b1;
            out_data_q  <= pool_res;
            out_last_q  <= (col_q == COL_LAST) && (row_q == ROW_LAST);
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Buffer contents need no reset: every entry is written on an even row before it is read.
   always_ff @(posedge clk) begin
      if (accept && col_q[0] && !row_q[0]) rowbuf_q[col_q[CW-1:1]] <= pair_res;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

endmodule
